// File: rtl/pipe_stall_ctrl_if.sv
// Stall-bus bundle between the pipeline stages and the central stall scheduler.
// The master side raises requests and supplies fetch data. The slave side is the scheduler.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              ex_done;
    logic [31:0]       inst_sram_rdata;
    logic [5:0]        stall;
    logic [31:0]       id_inst;
    logic              busy;
    logic              timeout_err;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, ex_done, inst_sram_rdata,
        input  stall, id_inst, busy, timeout_err, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_done, inst_sram_rdata,
        output stall, id_inst, busy, timeout_err, stall_cycles
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall scheduler: merges ID load-use and EX multi-cycle requests.
// It also bounds EX-busy waits with a timeout and holds the fetched word while IF/ID is frozen.
module pipe_stall_ctrl #(
    parameter int unsigned MAX_BUSY = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stall_ctrl_if.slave   bus
);
    localparam int unsigned BUSY_W = $clog2(MAX_BUSY);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(MAX_BUSY - 1);
    localparam logic [5:0] STALL_LDUSE  = 6'b000111;
    localparam logic [5:0] STALL_EXWAIT = 6'b001111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_EXBUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BUSY_W-1:0]  busy_cnt_q, busy_cnt_d;
    logic               timeout_set;
    logic               timeout_q;
    logic               hold_valid_q;
    logic [31:0]        hold_inst_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [5:0]         stall_c;
    logic [5:0]         stall_g;

    // Next-state and stall decode; EX requests win over ID requests.
    always_comb begin
        state_d     = state_q;
        busy_cnt_d  = busy_cnt_q;
        stall_c     = 6'b000000;
        timeout_set = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.stallreq_ex) begin
                    if (!bus.ex_done) begin
                        stall_c    = STALL_EXWAIT;
                        state_d    = ST_EXBUSY;
                        busy_cnt_d = '0;
                    end
                end else if (bus.stallreq_id) begin
                    stall_c = STALL_LDUSE;
                end
            end
            ST_EXBUSY: begin
                if (bus.ex_done) begin
                    state_d = ST_RUN;
                end else if (busy_cnt_q == BUSY_LAST) begin
                    state_d     = ST_RUN;
                    timeout_set = 1'b1;
                end else begin
                    stall_c    = STALL_EXWAIT;
                    busy_cnt_d = busy_cnt_q + BUSY_W'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Stall is forced low while reset is asserted, independent of requests.
    assign stall_g = rst ? stall_c : 6'b000000;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            busy_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= 32'h0;
            stall_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_cnt_q <= busy_cnt_d;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
            // Capture only the first frozen word; chained stalls keep it.
            if (!stall_g[1]) begin
                hold_valid_q <= 1'b0;
            end else if (stall_g[2] && !hold_valid_q) begin
                hold_inst_q  <= bus.inst_sram_rdata;
                hold_valid_q <= 1'b1;
            end
            if (stall_g[0] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall        = stall_g;
    assign bus.id_inst      = hold_valid_q ? hold_inst_q : bus.inst_sram_rdata;
    assign bus.busy         = (state_q == ST_EXBUSY);
    assign bus.timeout_err  = timeout_q;
    assign bus.stall_cycles = stall_cnt_q;
endmodule
